// File: rtl/match_pkg.sv
// match_pkg: shared widths, types and FSM state encoding for the match controller.
//   SCORE_W  - width of each player's score
//   CNT_W    - width of the frame countdown
//   STATE_W  - width of the FSM state / debug state output
package match_pkg;

    localparam int SCORE_W = 4;
    localparam int CNT_W   = 6;
    localparam int STATE_W = 3;

    typedef logic [SCORE_W-1:0] score_t;
    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [STATE_W-1:0] state_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SERVE = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_PAUSE = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;

endpackage

// File: rtl/match_ctrl_if.sv
// match_ctrl_if: game-control bundle between the match controller and its environment.
//   frame_tick, start_btn, point_valid, point_winner - stimulus into the controller
//   phys_en, ball_reset, serve_side                  - physics control out
//   p1_score, p2_score, match_over, winner, state_o  - match status out
//   master: the side driving stimulus; slave: the controller itself
interface match_ctrl_if;
    import match_pkg::*;

    logic   frame_tick;
    logic   start_btn;
    logic   point_valid;
    logic   point_winner;
    logic   phys_en;
    logic   ball_reset;
    logic   serve_side;
    score_t p1_score;
    score_t p2_score;
    logic   match_over;
    logic   winner;
    state_t state_o;

    modport master (
        output frame_tick, start_btn, point_valid, point_winner,
        input  phys_en, ball_reset, serve_side, p1_score, p2_score,
               match_over, winner, state_o
    );

    modport slave (
        input  frame_tick, start_btn, point_valid, point_winner,
        output phys_en, ball_reset, serve_side, p1_score, p2_score,
               match_over, winner, state_o
    );

endinterface

// File: rtl/frame_countdown.sv
// frame_countdown: saturating frame-tick down counter used for serve and pause delays.
//   clk, rst  - clock, synchronous active-high reset (count cleared to 0)
//   load      - load load_val (takes priority over tick)
//   load_val  - value to load
//   tick      - decrement by one, never below 0
//   zero      - this tick is the one that brings the count to 0
module frame_countdown
    import match_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  cnt_t load_val,
    input  logic tick,
    output logic zero
);

    cnt_t count;

    // Flagging the expiring tick itself lets the FSM leave its wait state on
    // the same edge the count reaches 0, so N loaded frames take exactly N ticks.
    assign zero = tick && (count <= cnt_t'(1));

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (tick && count != '0)
            count <= count - cnt_t'(1);
    end

endmodule

// File: rtl/match_ctrl.sv
// match_ctrl: serve/play/pause/match-over sequencer and scorekeeper for a two-player ball game.
//   WIN_SCORE    - points that win the match (1..15)
//   SERVE_FRAMES - frames the ball is held before play (1..63)
//   PAUSE_FRAMES - frames of freeze after a point (1..63)
//   clk, rst     - clock, synchronous active-high reset
//   bus          - match_ctrl_if.slave: frame/start/point inputs, physics control and status outputs
module match_ctrl
    import match_pkg::*;
#(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 30,
    parameter int PAUSE_FRAMES = 60
) (
    input logic         clk,
    input logic         rst,
    match_ctrl_if.slave bus
);

    localparam score_t WIN = score_t'(WIN_SCORE);
    localparam cnt_t   SRV = cnt_t'(SERVE_FRAMES);
    localparam cnt_t   PSE = cnt_t'(PAUSE_FRAMES);

    state_t state, state_nx;
    score_t p1, p2, p1_nx, p2_nx, pt_new;
    logic   serve, serve_nx, win, win_nx;
    logic   start_prev, start_rise;
    logic   ball_reset;
    logic   load, expire;
    cnt_t   load_val;

    assign start_rise = bus.start_btn && !start_prev;
    assign pt_new     = (bus.point_winner ? p2 : p1) + score_t'(1);

    frame_countdown u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .tick     (bus.frame_tick),
        .zero     (expire)
    );

    always_comb begin
        state_nx = state;
        p1_nx    = p1;
        p2_nx    = p2;
        serve_nx = serve;
        win_nx   = win;
        load     = 1'b0;
        load_val = SRV;
        case (state)
            ST_IDLE, ST_OVER: begin
                if (start_rise) begin
                    state_nx = ST_SERVE;
                    load     = 1'b1;
                    p1_nx    = '0;
                    p2_nx    = '0;
                    // A fresh match from IDLE hands the serve to P2; a rematch
                    // keeps whoever scored last.
                    serve_nx = (state == ST_IDLE) ? 1'b1 : serve;
                end
            end
            ST_SERVE: begin
                if (expire)
                    state_nx = ST_PLAY;
            end
            ST_PLAY: begin
                if (bus.point_valid) begin
                    serve_nx = bus.point_winner;
                    p1_nx    = bus.point_winner ? p1 : pt_new;
                    p2_nx    = bus.point_winner ? pt_new : p2;
                    if (pt_new == WIN) begin
                        state_nx = ST_OVER;
                        win_nx   = bus.point_winner;
                    end else begin
                        state_nx = ST_PAUSE;
                        load     = 1'b1;
                        load_val = PSE;
                    end
                end
            end
            ST_PAUSE: begin
                if (expire) begin
                    state_nx = ST_SERVE;
                    load     = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            p1         <= '0;
            p2         <= '0;
            serve      <= 1'b1;
            win        <= 1'b0;
            ball_reset <= 1'b0;
            start_prev <= 1'b0;
        end else begin
            state      <= state_nx;
            p1         <= p1_nx;
            p2         <= p2_nx;
            serve      <= serve_nx;
            win        <= win_nx;
            ball_reset <= (state_nx == ST_SERVE) && (state != ST_SERVE);
            start_prev <= bus.start_btn;
        end
    end

    assign bus.phys_en    = bus.frame_tick && (state == ST_PLAY);
    assign bus.ball_reset = ball_reset;
    assign bus.serve_side = serve;
    assign bus.p1_score   = p1;
    assign bus.p2_score   = p2;
    assign bus.match_over = (state == ST_OVER);
    assign bus.winner     = win;
    assign bus.state_o    = state;

endmodule

// File: tb/tb_match_ctrl.sv
// tb_match_ctrl: directed scenarios plus random stimulus checked against a rule-level match model.
module tb_match_ctrl;
    import match_pkg::*;

    localparam int WIN = 3;
    localparam int SRV = 3;
    localparam int PSE = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    match_ctrl_if bus();

    match_ctrl #(.WIN_SCORE(WIN), .SERVE_FRAMES(SRV), .PAUSE_FRAMES(PSE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef enum int {M_IDLE, M_SERVE, M_PLAY, M_PAUSE, M_OVER} mphase_t;

    mphase_t ph = M_IDLE;
    int      left = 0;
    int      sc[2] = '{0, 0};
    bit      srv = 1'b1, wnr = 1'b0, br = 1'b0, prev = 1'b0;
    bit      sb = 1'b0;
    int      total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        total++;
        if (got !== 32'(exp)) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int enc(input mphase_t p);
        case (p)
            M_SERVE: return int'(ST_SERVE);
            M_PLAY:  return int'(ST_PLAY);
            M_PAUSE: return int'(ST_PAUSE);
            M_OVER:  return int'(ST_OVER);
            default: return int'(ST_IDLE);
        endcase
    endfunction

    task automatic model(input bit r, input bit t, input bit s, input bit v, input bit w);
        bit rise;
        br = 1'b0;
        if (r) begin
            ph = M_IDLE; left = 0; sc[0] = 0; sc[1] = 0;
            srv = 1'b1; wnr = 1'b0; prev = 1'b0;
            return;
        end
        rise = s && !prev;
        prev = s;
        case (ph)
            M_IDLE, M_OVER: if (rise) begin
                if (ph == M_IDLE) srv = 1'b1;
                sc[0] = 0; sc[1] = 0;
                left = SRV; ph = M_SERVE; br = 1'b1;
            end
            M_SERVE: if (t) begin
                left--;
                if (left == 0) ph = M_PLAY;
            end
            M_PLAY: if (v) begin
                sc[w]++;
                srv = w;
                if (sc[w] == WIN) begin ph = M_OVER; wnr = w; end
                else begin left = PSE; ph = M_PAUSE; end
            end
            M_PAUSE: if (t) begin
                left--;
                if (left == 0) begin left = SRV; ph = M_SERVE; br = 1'b1; end
            end
            default: ;
        endcase
    endtask

    task automatic step(input bit r, input bit t, input bit s, input bit v, input bit w);
        rst = r;
        bus.frame_tick = t;
        bus.start_btn = s;
        bus.point_valid = v;
        bus.point_winner = w;
        #2;
        chk("phys_en", 32'(bus.phys_en), int'(t && ph == M_PLAY));
        @(posedge clk);
        model(r, t, s, v, w);
        #1;
        chk("state", 32'(bus.state_o), enc(ph));
        chk("p1_score", 32'(bus.p1_score), sc[0]);
        chk("p2_score", 32'(bus.p2_score), sc[1]);
        chk("serve_side", 32'(bus.serve_side), int'(srv));
        chk("ball_reset", 32'(bus.ball_reset), int'(br));
        chk("match_over", 32'(bus.match_over), int'(ph == M_OVER));
        if (ph == M_OVER) chk("winner", 32'(bus.winner), int'(wnr));
    endtask

    task automatic idle();
        step(0, 0, sb, 0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 1, sb, 0, 0);
            idle();
        end
    endtask

    task automatic press();
        sb = 0; idle();
        sb = 1; idle();
    endtask

    task automatic point(input bit w);
        step(0, 0, sb, 1, w);
    endtask

    initial begin
        rst = 1'b1;
        bus.frame_tick = 0; bus.start_btn = 0; bus.point_valid = 0; bus.point_winner = 0;
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // serve delay, a P1 point with start held, ignored points in PAUSE/SERVE
        press();
        ticks(SRV);
        point(0);
        step(0, 0, sb, 1, 1);
        ticks(PSE);
        step(0, 0, sb, 1, 1);
        ticks(SRV);
        // point coincident with a frame tick
        step(0, 1, sb, 1, 1);
        ticks(PSE);
        ticks(SRV);
        point(0);
        step(0, 1, sb, 0, 0);
        // reset in PAUSE at 2:1
        step(1, 0, sb, 0, 0);
        idle();
        // P2 wins the match, then extra points are ignored, then rematch
        press();
        for (int k = 0; k < WIN; k++) begin
            ticks(SRV);
            point(1);
            if (k < WIN - 1) ticks(PSE);
        end
        point(0);
        step(0, 1, sb, 1, 1);
        idle();
        press();
        ticks(SRV);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) sb = ~sb;
            step(bit'($urandom_range(0, 599) == 0), bit'($urandom_range(0, 2) == 0), sb,
                 bit'($urandom_range(0, 5) == 0), bit'($urandom_range(0, 1)));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/match_ctrl.md
MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 7, points needed to win the match; legal range 1..15.
REQ-002 Parameter SERVE_FRAMES, default 30, frame ticks the ball is held before play; legal range 1..63.
REQ-003 Parameter PAUSE_FRAMES, default 60, frame ticks of freeze after a point; legal range 1..63.
REQ-004 clk  in  1  single system clock; every register is clocked on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 frame_tick  in  1  one-cycle pulse per video frame.
REQ-007 start_btn  in  1  level input; the block detects its rising edge internally.
REQ-008 point_valid  in  1  one-cycle pulse from the physics datapath: ball touched the floor.
REQ-009 point_winner  in  1  scorer of that point, valid with point_valid (0 = P1, 1 = P2).
REQ-010 phys_en  out  1  physics step enable.
REQ-011 ball_reset  out  1  one-cycle pulse: physics reloads ball at serve position, zero velocity.
REQ-012 serve_side  out  1  side that serves next (0 = P1, 1 = P2).
REQ-013 p1_score, p2_score  out  4 each  match scores.
REQ-014 match_over  out  1  high while in MATCH_OVER.
REQ-015 winner  out  1  match winner; valid while match_over is high.
REQ-016 state_o  out  3  current state encoding, for debug.

Function
REQ-017 The block SHALL implement states IDLE, SERVE, PLAY, PAUSE and MATCH_OVER.
REQ-018 phys_en SHALL equal frame_tick AND (state==PLAY), combinationally from the registered state.
REQ-019 start_rise SHALL be asserted when start_btn=1 and the registered previous start_btn=0.
REQ-020 IDLE: on start_rise the block SHALL clear both scores, set serve_side=1, load the counter with SERVE_FRAMES and enter SERVE.
REQ-021 SERVE: each frame_tick SHALL decrement the counter; the tick that brings the counter to 0 SHALL move the state to PLAY on the next edge; phys_en SHALL stay low for that tick.
REQ-022 PLAY: on point_valid the block SHALL increment the scorer's score and set serve_side=point_winner.
REQ-023 On that point, if the new score equals WIN_SCORE, the block SHALL enter MATCH_OVER and latch winner=point_winner.
REQ-024 Otherwise the block SHALL load PAUSE_FRAMES and enter PAUSE.
REQ-025 PAUSE: each frame_tick SHALL decrement the counter; at 0 the block SHALL load SERVE_FRAMES and enter SERVE.
REQ-026 ball_reset SHALL be a registered pulse, high exactly in the cycle after any transition into SERVE.
REQ-027 MATCH_OVER: the block SHALL hold scores and winner.
REQ-028 In MATCH_OVER, on start_rise the block SHALL clear scores, keep serve_side, load SERVE_FRAMES and enter SERVE.
REQ-029 point_valid outside PLAY SHALL be ignored: no score change, no state change.
REQ-030 start_rise outside IDLE and MATCH_OVER SHALL be ignored.
REQ-031 When point_valid and frame_tick coincide in PLAY, phys_en SHALL be asserted and the point SHALL be processed in the same cycle.
REQ-032 Scores SHALL never exceed WIN_SCORE; no increment SHALL occur once match_over is high.
REQ-033 The counter SHALL be 6 bits, unsigned; it SHALL never decrement below 0 and SHALL not wrap.

Reset
REQ-034 With rst high at a clock edge, the block SHALL set state=IDLE, p1_score=0, p2_score=0, serve_side=1, match_over=0, winner=0, ball_reset=0, counter=0, and previous start_btn=0.
REQ-035 Asserting rst mid-operation (any state) SHALL abort the match with no ball_reset pulse; phys_en SHALL be 0 from the next cycle.

Structure
REQ-036 State encoding, the 4-bit score width and the 6-bit counter width SHALL live in shared package match_pkg.
REQ-037 Frame counting SHALL be a sub-module frame_countdown with ports: load, load_val, tick, zero.

Verification
REQ-038 Scenario 1: rst, then start_btn rises; SERVE_FRAMES=3 -> ball_reset high the cycle after, PLAY entered after the 3rd frame_tick, phys_en first high on the 4th tick.
REQ-039 Scenario 2: in PLAY, point_valid with point_winner=0 -> p1_score=1, serve_side=0, state PAUSE; with PAUSE_FRAMES=4, SERVE re-entered after 4 ticks and ball_reset pulses once.
REQ-040 Scenario 3: WIN_SCORE=3, P2 scores 3 points -> match_over=1, winner=1, p2_score=3; a further point_valid leaves scores unchanged.
REQ-041 Scenario 4: point_valid during SERVE/PAUSE and start_btn held high in PLAY -> no score, state or serve changes.
REQ-042 Scenario 5: rst asserted in PAUSE with scores 2:1 -> next cycle state=IDLE, scores 0:0, ball_reset=0, phys_en=0.
REQ-043 Scenario 6: point_valid coincident with frame_tick in PLAY -> phys_en=1 that cycle, score increments once.
